// File: rtl/sprite_pkg.sv
// Shared types for the sprite list path: packed sprite entry, default field widths
// derived from the canvas geometry, and the replay FSM state encoding.
package sprite_pkg;

  localparam int unsigned DEF_CANVAS_WIDTH  = 360;
  localparam int unsigned DEF_CANVAS_HEIGHT = 720;
  localparam int unsigned DEF_NUM_FRAMES    = 5;
  localparam int unsigned DEF_MAX_SPRITES   = 64;

  localparam int unsigned SPRITE_X_W     = $clog2(DEF_CANVAS_WIDTH);
  localparam int unsigned SPRITE_Y_W     = $clog2(DEF_CANVAS_HEIGHT);
  localparam int unsigned SPRITE_FRAME_W = $clog2(DEF_NUM_FRAMES);
  localparam int unsigned SPRITE_COUNT_W = $clog2(DEF_MAX_SPRITES + 1);

  typedef struct packed {
    logic [SPRITE_X_W-1:0]     x;
    logic [SPRITE_Y_W-1:0]     y;
    logic [SPRITE_FRAME_W-1:0] frame;
  } sprite_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } sprite_list_state_t;

endpackage

// File: rtl/sprite_bank_ram.sv
// Two-bank sprite storage: one synchronous write port, one synchronous read port whose
// registered output doubles as the replay output register.
module sprite_bank_ram #(
  parameter int unsigned DATA_W = 22,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register only advances on rd_en so the replay output holds during stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sprite_list_buffer.sv
// Double-banked sprite list: captures the producer's per-frame sprite stream into one bank
// while the previously completed list is replayed to graphics over valid/ready.
module sprite_list_buffer
  import sprite_pkg::*;
#(
  parameter int unsigned CANVAS_WIDTH  = DEF_CANVAS_WIDTH,
  parameter int unsigned CANVAS_HEIGHT = DEF_CANVAS_HEIGHT,
  parameter int unsigned NUM_FRAMES    = DEF_NUM_FRAMES,
  parameter int unsigned MAX_SPRITES   = DEF_MAX_SPRITES,
  localparam int unsigned XW = $clog2(CANVAS_WIDTH),
  localparam int unsigned YW = $clog2(CANVAS_HEIGHT),
  localparam int unsigned FW = $clog2(NUM_FRAMES),
  localparam int unsigned CW = $clog2(MAX_SPRITES + 1)
) (
  input  logic          clk_pixel,
  input  logic          sys_rst,
  input  logic          new_frame,
  input  logic          in_valid,
  input  logic [XW-1:0] in_x,
  input  logic [YW-1:0] in_y,
  input  logic [FW-1:0] in_frame,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [FW-1:0] out_frame,
  input  logic          out_ready,
  output logic          list_done,
  output logic [CW-1:0] sprite_count,
  output logic          overflow
);

  localparam int unsigned DW = XW + YW + FW;
  localparam int unsigned IW = $clog2(MAX_SPRITES);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SPRITES);

  logic          wr_bank;
  logic          rd_bank;
  logic [CW-1:0] wr_count;
  logic          overflow_pending;
  logic          wr_accept;
  logic          wr_drop;
  logic [CW-1:0] final_count;

  sprite_list_state_t state, state_next;
  logic [CW-1:0] rd_idx, rd_idx_next, rd_idx_inc;
  logic          out_valid_next;
  logic          rd_load;
  logic [IW-1:0] load_idx;
  logic [DW-1:0] rd_data;

  assign wr_accept   = in_valid && (wr_count < MAX_CNT);
  assign wr_drop     = in_valid && (wr_count == MAX_CNT);
  assign final_count = wr_count + CW'(wr_accept);
  assign rd_idx_inc  = rd_idx + CW'(1);

  // A write in the swap cycle still lands in the retiring bank and is included in its count.
  always_ff @(posedge clk_pixel or posedge sys_rst) begin
    if (sys_rst) begin
      wr_bank          <= 1'b0;
      rd_bank          <= 1'b0;
      wr_count         <= '0;
      sprite_count     <= '0;
      overflow         <= 1'b0;
      overflow_pending <= 1'b0;
    end else if (new_frame) begin
      rd_bank          <= wr_bank;
      sprite_count     <= final_count;
      wr_bank          <= ~wr_bank;
      wr_count         <= '0;
      overflow         <= overflow_pending | wr_drop;
      overflow_pending <= 1'b0;
    end else begin
      if (wr_accept) wr_count <= final_count;
      if (wr_drop)   overflow_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk_pixel or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      rd_idx    <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      rd_idx    <= rd_idx_next;
      out_valid <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state;
    rd_idx_next    = rd_idx;
    out_valid_next = out_valid;
    rd_load        = 1'b0;
    load_idx       = IW'(rd_idx);
    if (new_frame) begin
      state_next     = LOAD;
      rd_idx_next    = '0;
      out_valid_next = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        LOAD: begin
          if (sprite_count == '0) begin
            state_next = DONE;
          end else begin
            rd_load        = 1'b1;
            out_valid_next = 1'b1;
            state_next     = STREAM;
          end
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            rd_idx_next = rd_idx_inc;
            if (rd_idx_inc == sprite_count) begin
              out_valid_next = 1'b0;
              state_next     = DONE;
            end else begin
              rd_load  = 1'b1;
              load_idx = IW'(rd_idx_inc);
            end
          end
        end
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign list_done = (state == DONE);

  sprite_bank_ram #(
    .DATA_W (DW),
    .ADDR_W (IW + 1)
  ) u_bank_ram (
    .clk     (clk_pixel),
    .rst     (sys_rst),
    .wr_en   (wr_accept),
    .wr_addr ({wr_bank, IW'(wr_count)}),
    .wr_data ({in_x, in_y, in_frame}),
    .rd_en   (rd_load),
    .rd_addr ({rd_bank, load_idx}),
    .rd_data (rd_data)
  );

  assign out_x     = rd_data[DW-1 -: XW];
  assign out_y     = rd_data[FW +: YW];
  assign out_frame = rd_data[FW-1:0];

endmodule

// File: tb/tb_sprite_list_buffer.sv
// Bench for sprite_list_buffer: list-level reference model checked every cycle, plus
// directed vectors with literal expectations.
module tb_sprite_list_buffer;
  import sprite_pkg::*;

  localparam int MAXS = 64;

  logic       clk_pixel = 1'b0;
  logic       sys_rst   = 1'b1;
  logic       new_frame = 1'b0;
  logic       in_valid  = 1'b0;
  logic [8:0] in_x      = '0;
  logic [9:0] in_y      = '0;
  logic [2:0] in_frame  = '0;
  logic       out_valid;
  logic [8:0] out_x;
  logic [9:0] out_y;
  logic [2:0] out_frame;
  logic       out_ready = 1'b0;
  logic       list_done;
  logic [6:0] sprite_count;
  logic       overflow;

  sprite_list_buffer #(
    .CANVAS_WIDTH  (360),
    .CANVAS_HEIGHT (720),
    .NUM_FRAMES    (5),
    .MAX_SPRITES   (64)
  ) dut (
    .clk_pixel    (clk_pixel),
    .sys_rst      (sys_rst),
    .new_frame    (new_frame),
    .in_valid     (in_valid),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_frame     (in_frame),
    .out_valid    (out_valid),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_frame    (out_frame),
    .out_ready    (out_ready),
    .list_done    (list_done),
    .sprite_count (sprite_count),
    .overflow     (overflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame being written, list being replayed, cycles since the swap.
  sprite_t m_w[$];
  sprite_t m_q[$];
  int      m_count = 0;
  bit      m_pend  = 0;
  bit      m_ovf   = 0;
  bit      m_on    = 0;
  int      m_age   = 0;
  bit      ev, ed;

  always @(negedge clk_pixel) begin
    if (sys_rst) begin
      m_w.delete(); m_q.delete();
      m_count = 0; m_pend = 0; m_ovf = 0; m_on = 0; m_age = 0;
    end else begin
      ev = m_on && (m_age >= 2) && (m_q.size() > 0);
      ed = m_on && (m_age >= 2) && (m_q.size() == 0);
      check("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        check("out_x", 32'(out_x), 32'(m_q[0].x));
        check("out_y", 32'(out_y), 32'(m_q[0].y));
        check("out_frame", 32'(out_frame), 32'(m_q[0].frame));
      end
      check("list_done", 32'(list_done), 32'(ed));
      check("sprite_count", 32'(sprite_count), 32'(m_count));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (in_valid) begin
        if (m_w.size() < MAXS) m_w.push_back('{x: in_x, y: in_y, frame: in_frame});
        else m_pend = 1;
      end
      if (new_frame) begin
        m_q = m_w; m_count = m_w.size(); m_ovf = m_pend;
        m_w.delete(); m_pend = 0; m_on = 1; m_age = 1;
      end else if (m_on) begin
        if (ev && out_ready) void'(m_q.pop_front());
        if (ed) m_on = 0;
        m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_pixel); #1;
  endtask

  task automatic put(input int x, input int y, input int f);
    in_valid = 1'b1; in_x = 9'(x); in_y = 10'(y); in_frame = 3'(f);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_nf();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  int dn;

  initial begin
    tick(); tick();
    sys_rst = 1'b0;
    @(negedge clk_pixel);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sprite_count", 32'(sprite_count), 0);
    check("rst_list_done", 32'(list_done), 0);
    tick();

    // 1: empty list
    pulse_nf();
    @(negedge clk_pixel);
    check("t1_done_t1", 32'(list_done), 0);
    tick();
    @(negedge clk_pixel);
    check("t1_done_t2", 32'(list_done), 1);
    check("t1_count", 32'(sprite_count), 0);
    tick(); tick();

    // 2: three entries, full ready
    out_ready = 1'b1;
    put(10, 20, 1); put(30, 40, 2); put(359, 719, 4);
    pulse_nf();
    tick();
    @(negedge clk_pixel);
    check("t2_e0", {out_valid, 13'(out_x), 15'(out_y), 3'(out_frame)}, {1'b1, 13'd10, 15'd20, 3'd1});
    tick();
    @(negedge clk_pixel);
    check("t2_e1", {out_valid, 13'(out_x), 15'(out_y), 3'(out_frame)}, {1'b1, 13'd30, 15'd40, 3'd2});
    tick();
    @(negedge clk_pixel);
    check("t2_e2", {out_valid, 13'(out_x), 15'(out_y), 3'(out_frame)}, {1'b1, 13'd359, 15'd719, 3'd4});
    tick();
    @(negedge clk_pixel);
    check("t2_done", 32'(list_done), 1);
    check("t2_count", 32'(sprite_count), 3);
    tick(); tick();

    // 3: same list, ready toggling
    put(10, 20, 1); put(30, 40, 2); put(359, 719, 4);
    pulse_nf();
    dn = 0;
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 2 == 0);
      @(negedge clk_pixel);
      if (list_done) dn++;
      tick();
    end
    check("t3_done_pulses", 32'(dn), 1);

    // 4: overflow
    out_ready = 1'b1;
    for (int i = 0; i < 66; i++) put(i, 2 * i, i % 5);
    pulse_nf();
    @(negedge clk_pixel);
    check("t4_count", 32'(sprite_count), 64);
    check("t4_overflow", 32'(overflow), 1);
    for (int i = 0; i < 70; i++) tick();
    put(7, 8, 0); put(9, 10, 1);
    pulse_nf();
    @(negedge clk_pixel);
    check("t4_next_overflow", 32'(overflow), 0);
    check("t4_next_count", 32'(sprite_count), 2);
    for (int i = 0; i < 6; i++) tick();

    // 5: write in the swap cycle
    put(1, 2, 0); put(3, 4, 1);
    in_valid = 1'b1; in_x = 9'd5; in_y = 10'd6; in_frame = 3'd3; new_frame = 1'b1;
    tick();
    in_valid = 1'b0; new_frame = 1'b0;
    @(negedge clk_pixel);
    check("t5_count", 32'(sprite_count), 3);
    tick(); tick(); tick();
    @(negedge clk_pixel);
    check("t5_last_x", 32'(out_x), 5);
    check("t5_last_frame", 32'(out_frame), 3);
    tick(); tick(); tick();

    // 6: abort mid-replay, then reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) put(100 + i, 200 + i, i % 5);
    pulse_nf();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk_pixel);
    check("t6_second_x", {31'(out_x), out_valid}, {31'd101, 1'b1});
    tick();
    put(50, 60, 2); put(70, 80, 3);
    pulse_nf();
    @(negedge clk_pixel);
    check("t6_abort_valid", 32'(out_valid), 0);
    check("t6_abort_done", 32'(list_done), 0);
    tick();
    @(negedge clk_pixel);
    check("t6_new_first_x", {31'(out_x), out_valid}, {31'd50, 1'b1});
    tick(); tick();
    sys_rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_count", 32'(sprite_count), 0);
    tick(); tick();
    sys_rst = 1'b0;
    tick();
    pulse_nf();
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
